rank_op_pipe: RTL



---
 rtl/rank_op_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rank_op_pipe.sv
// rank_op_pipe: buffers insert requests, assigns each packet a rank (SRPT, FIFO sequence or STFQ start time)
// and presents {rank, meta, op} to a downstream PIFO through an output fallthrough FIFO.
module rop_fifo #(
    parameter int W  = 8,
    parameter int L2 = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en_i,
    input  logic [W-1:0] din_i,
    input  logic         rd_en_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         nearly_full_o
);
    localparam int DEPTH = 2**L2;
    logic [W-1:0]  mem_q [DEPTH];
    logic [L2-1:0] wr_ptr_q, rd_ptr_q;
    logic [L2:0]   cnt_q;
    assign dout_o        = mem_q[rd_ptr_q];
    assign empty_o       = cnt_q == '0;
    assign nearly_full_o = cnt_q >= (L2+1)'(DEPTH-1);
    always_ff @(posedge clk) if (wr_en_i) mem_q[wr_ptr_q] <= din_i;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + L2'(wr_en_i);
            rd_ptr_q <= rd_ptr_q + L2'(rd_en_i);
            cnt_q    <= cnt_q + (L2+1)'(wr_en_i) - (L2+1)'(rd_en_i);
        end
    end
endmodule

module rank_op_pipe #(
    parameter int RANK_CODE_BITS = 2,
    parameter int RANK_WIDTH     = 16,
    parameter int META_WIDTH     = 16,
    parameter int FLOW_ID_WIDTH  = 4,
    parameter int PKT_LEN_WIDTH  = 11,
    parameter int L2_FIFO_DEPTH  = 6,
    parameter int SRPT_OP        = 0,
    parameter int FIFO_OP        = 1,
    parameter int STFQ_OP        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      busy,
    input  logic                      insert,
    input  logic [META_WIDTH-1:0]     meta_in,
    input  logic [RANK_CODE_BITS-1:0] rank_op_in,
    input  logic [RANK_WIDTH-1:0]     srpt_rank_in,
    input  logic [FLOW_ID_WIDTH-1:0]  flow_id_in,
    input  logic [PKT_LEN_WIDTH-1:0]  pkt_len_in,
    input  logic                      remove,
    output logic                      valid_out,
    output logic [RANK_WIDTH-1:0]     rank_out,
    output logic [META_WIDTH-1:0]     meta_out,
    output logic [RANK_CODE_BITS-1:0] rank_op_out,
    output logic [31:0]               drop_count
);
    localparam int NUM_FLOWS = 2**FLOW_ID_WIDTH;
    localparam int IW = RANK_CODE_BITS + META_WIDTH + RANK_WIDTH + FLOW_ID_WIDTH + PKT_LEN_WIDTH;
    localparam int OW = RANK_WIDTH + META_WIDTH + RANK_CODE_BITS;
    logic                      in_empty, in_nf, out_empty, out_nf, compute, pop;
    logic [IW-1:0]             in_dout;
    logic [OW-1:0]             out_dout;
    logic [RANK_CODE_BITS-1:0] h_op;
    logic [META_WIDTH-1:0]     h_meta;
    logic [RANK_WIDTH-1:0]     h_srpt;
    logic [FLOW_ID_WIDTH-1:0]  h_flow;
    logic [PKT_LEN_WIDTH-1:0]  h_len;
    logic                      is_srpt, is_fifo, is_stfq;
    logic [RANK_WIDTH-1:0]     seq_q, vtime_q, lf, start, finish_d, rank;
    logic [RANK_WIDTH:0]       sum;
    logic [RANK_WIDTH-1:0]     last_finish_q [NUM_FLOWS];
    logic [31:0]               drop_q;

    rop_fifo #(.W(IW), .L2(L2_FIFO_DEPTH)) u_in (
        .clk(clk), .rst(rst),
        .wr_en_i(insert && !in_nf),
        .din_i({rank_op_in, meta_in, srpt_rank_in, flow_id_in, pkt_len_in}),
        .rd_en_i(compute), .dout_o(in_dout),
        .empty_o(in_empty), .nearly_full_o(in_nf)
    );

    rop_fifo #(.W(OW), .L2(L2_FIFO_DEPTH)) u_out (
        .clk(clk), .rst(rst),
        .wr_en_i(compute), .din_i({rank, h_meta, h_op}),
        .rd_en_i(pop), .dout_o(out_dout),
        .empty_o(out_empty), .nearly_full_o(out_nf)
    );

    assign busy       = in_nf;
    assign valid_out  = !out_empty;
    assign pop        = remove && valid_out;
    assign compute    = !in_empty && !out_nf;
    assign drop_count = drop_q;
    assign {h_op, h_meta, h_srpt, h_flow, h_len} = in_dout;
    assign {rank_out, meta_out, rank_op_out}     = out_dout;
    assign is_srpt = h_op == RANK_CODE_BITS'(SRPT_OP);
    assign is_fifo = h_op == RANK_CODE_BITS'(FIFO_OP);
    assign is_stfq = h_op == RANK_CODE_BITS'(STFQ_OP);

    // Unknown op codes get the lowest priority rank.
    always_comb begin
        lf       = last_finish_q[h_flow];
        start    = vtime_q > lf ? vtime_q : lf;
        sum      = {1'b0, start} + (RANK_WIDTH+1)'(h_len);
        finish_d = sum[RANK_WIDTH] ? '1 : sum[RANK_WIDTH-1:0];
        rank     = is_srpt ? h_srpt : is_fifo ? seq_q : is_stfq ? start : '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q   <= '0;
            vtime_q <= '0;
            drop_q  <= '0;
            for (int i = 0; i < NUM_FLOWS; i++) last_finish_q[i] <= '0;
        end else begin
            if (compute && is_fifo) seq_q <= seq_q + 1'b1;
            if (compute && is_stfq) last_finish_q[h_flow] <= finish_d;
            if (pop && rank_op_out == RANK_CODE_BITS'(STFQ_OP)) vtime_q <= rank_out;
            if (insert && in_nf && drop_q != '1) drop_q <= drop_q + 32'd1;
        end
    end
endmodule
